// File: rtl/snake_dir_if.sv
// Button inputs and status outputs of the snake direction controller.
// The bench drives the buttons through master; the controller uses the slave view.
interface snake_dir_if #(
  parameter int QAW = 2
);
  logic           arriba;
  logic           abajo;
  logic           izquierda;
  logic           derecha;
  logic           pausa;
  logic [2:0]     accion;
  logic [3:0]     estado;
  logic           paso;
  logic           pausado;
  logic [QAW:0]   q_count;
  logic           q_overflow;

  modport master (
    output arriba, abajo, izquierda, derecha, pausa,
    input  accion, estado, paso, pausado, q_count, q_overflow
  );

  modport slave (
    input  arriba, abajo, izquierda, derecha, pausa,
    output accion, estado, paso, pausado, q_count, q_overflow
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: button edges queue commands, one is applied per movement tick.
// Commands are queued on the press edge; estado/accion/paso change the cycle after a tick.
module snake_dir_ctrl #(
  parameter int TICK_CYCLES = 50000000,
  parameter int QDEPTH      = 4,
  parameter int QAW         = 2
) (
  input  logic      clk,
  input  logic      rst,
  snake_dir_if.slave bus
);
  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIO = 4'd0, M_ARR = 4'd1, M_ABA = 4'd2, M_IZQ = 4'd3, M_DER = 4'd4,
    P_ARR  = 4'd5, P_ABA = 4'd6, P_DER = 4'd7, P_IZQ = 4'd8
  } state_t;

  logic [CW-1:0]  tick_cnt;
  logic           tick;
  logic [4:0]     btn, btn_prev, rise;
  logic           armed;
  logic [2:0]     cmd_in, cmd_pop;
  logic [2:0]     mem [QDEPTH];
  logic [QAW-1:0] wr_ptr, rd_ptr;
  logic [QAW:0]   count;
  logic           ovf, full, empty, push, pop;
  state_t         state, state_nxt;
  logic [2:0]     accion;
  logic           paso, pausado;

  // armed stays low for the first cycle after reset so a button held through release is ignored
  assign btn  = {bus.pausa, bus.arriba, bus.abajo, bus.izquierda, bus.derecha};
  assign rise = armed ? (btn & ~btn_prev) : 5'd0;

  always_comb begin
    cmd_in = 3'd0;
    if (rise[4])      cmd_in = 3'd5;
    else if (rise[3]) cmd_in = 3'd1;
    else if (rise[2]) cmd_in = 3'd2;
    else if (rise[1]) cmd_in = 3'd3;
    else if (rise[0]) cmd_in = 3'd4;
  end

  assign tick    = (tick_cnt == TICK_LAST);
  assign full    = (count == (QAW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign push    = (cmd_in != 3'd0) && !full;
  assign pop     = tick && !empty;
  assign cmd_pop = empty ? 3'd0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_prev <= 5'd0;
      armed    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      btn_prev <= btn;
      armed    <= 1'b1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (QAW+1)'(push) - (QAW+1)'(pop);
      if ((cmd_in != 3'd0) && full) ovf <= 1'b1;
    end
  end

  function automatic state_t next_state(input state_t s, input logic [2:0] c);
    next_state = s;
    case (s)
      INICIO: begin
        if (c == 3'd1)      next_state = M_ARR;
        else if (c == 3'd2) next_state = M_ABA;
        else if (c == 3'd3) next_state = M_IZQ;
        else if (c == 3'd4) next_state = M_DER;
      end
      M_ARR, M_ABA: begin
        if (c == 3'd3)      next_state = M_IZQ;
        else if (c == 3'd4) next_state = M_DER;
        else if (c == 3'd5) next_state = (s == M_ARR) ? P_ARR : P_ABA;
      end
      M_IZQ, M_DER: begin
        if (c == 3'd1)      next_state = M_ARR;
        else if (c == 3'd2) next_state = M_ABA;
        else if (c == 3'd5) next_state = (s == M_IZQ) ? P_IZQ : P_DER;
      end
      P_ARR: if (c == 3'd5) next_state = M_ARR;
      P_ABA: if (c == 3'd5) next_state = M_ABA;
      P_DER: if (c == 3'd5) next_state = M_DER;
      P_IZQ: if (c == 3'd5) next_state = M_IZQ;
      default: next_state = INICIO;
    endcase
  endfunction

  // accion is fully determined by the state: the direction in a move state, else none
  function automatic logic [2:0] move_of(input state_t s);
    case (s)
      M_ARR:   move_of = 3'd1;
      M_ABA:   move_of = 3'd2;
      M_IZQ:   move_of = 3'd3;
      M_DER:   move_of = 3'd4;
      default: move_of = 3'd0;
    endcase
  endfunction

  assign state_nxt = next_state(state, cmd_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= INICIO;
      accion  <= 3'd0;
      paso    <= 1'b0;
      pausado <= 1'b0;
    end else begin
      paso <= 1'b0;
      if (tick) begin
        state   <= state_nxt;
        accion  <= move_of(state_nxt);
        paso    <= (move_of(state_nxt) != 3'd0);
        pausado <= (state_nxt inside {P_ARR, P_ABA, P_DER, P_IZQ});
      end
    end
  end

  assign bus.estado     = state;
  assign bus.accion     = accion;
  assign bus.paso       = paso;
  assign bus.pausado    = pausado;
  assign bus.q_count    = count;
  assign bus.q_overflow = ovf;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random button/reset traffic,
// every cycle compared against a queue-based behavioural model.
module tb_snake_dir_ctrl;
  localparam int TICK = 4;
  localparam int QD   = 4;
  localparam int QAW  = 2;
  localparam logic [4:0] B_DER = 5'b00001;
  localparam logic [4:0] B_IZQ = 5'b00010;
  localparam logic [4:0] B_ABA = 5'b00100;
  localparam logic [4:0] B_ARR = 5'b01000;
  localparam logic [4:0] B_PAU = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_v = 5'd0;
  logic [4:0] rb = 5'd0;

  always #5 clk = ~clk;

  snake_dir_if #(.QAW(QAW)) bus ();

  assign bus.derecha   = btn_v[0];
  assign bus.izquierda = btn_v[1];
  assign bus.abajo     = btn_v[2];
  assign bus.arriba    = btn_v[3];
  assign bus.pausa     = btn_v[4];

  snake_dir_ctrl #(.TICK_CYCLES(TICK), .QDEPTH(QD), .QAW(QAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int paso_seen = 0;

  // model: mode 0 = start, 1 = moving in m_dir, 2 = paused while facing m_dir
  int         q[$];
  bit         m_ovf;
  int         m_cnt;
  int         m_mode;
  int         m_dir;
  bit         m_paso;
  bit [4:0]   m_prev;
  bit         m_fresh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_estado();
    if (m_mode == 0) return 0;
    if (m_mode == 1) return m_dir;
    case (m_dir)
      1: return 5;
      2: return 6;
      3: return 8;
      default: return 7;
    endcase
  endfunction

  task automatic model_edge();
    bit [4:0] r;
    int       c;
    int       popped;
    bit       tk;
    bit       was_full;
    if (!rst) begin
      q.delete();
      m_ovf = 0; m_cnt = 0; m_mode = 0; m_dir = 0;
      m_paso = 0; m_prev = 0; m_fresh = 1;
    end else begin
      r = m_fresh ? 5'd0 : (btn_v & ~m_prev);
      m_prev  = btn_v;
      m_fresh = 0;
      c = r[4] ? 5 : r[3] ? 1 : r[2] ? 2 : r[1] ? 3 : r[0] ? 4 : 0;
      tk = (m_cnt == TICK - 1);
      m_cnt = (m_cnt + 1) % TICK;
      was_full = (q.size() == QD);
      popped = 0;
      if (tk && q.size() > 0) popped = q.pop_front();
      if (c != 0) begin
        if (was_full) m_ovf = 1;
        else q.push_back(c);
      end
      m_paso = 0;
      if (tk) begin
        case (m_mode)
          0: if (popped >= 1 && popped <= 4) begin m_mode = 1; m_dir = popped; end
          1: begin
            if (popped == 5) m_mode = 2;
            else if (popped >= 1 && popped <= 4 && ((popped <= 2) != (m_dir <= 2))) m_dir = popped;
          end
          default: if (popped == 5) m_mode = 1;
        endcase
        m_paso = (m_mode == 1);
      end
    end
  endtask

  task automatic step(input logic [4:0] b, input logic r);
    btn_v = b;
    rst   = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("estado",     32'(bus.estado),     32'(exp_estado()));
    chk("accion",     32'(bus.accion),     32'((m_mode == 1) ? m_dir : 0));
    chk("paso",       32'(bus.paso),       32'(m_paso));
    chk("pausado",    32'(bus.pausado),    32'(m_mode == 2));
    chk("q_count",    32'(bus.q_count),    32'(q.size()));
    chk("q_overflow", 32'(bus.q_overflow), 32'(m_ovf));
    if (bus.paso === 1'b1) paso_seen++;
  endtask

  task automatic reset_seq();
    step(5'd0, 1'b0);
    step(5'd0, 1'b0);
    step(5'd0, 1'b1);
  endtask

  initial begin
    // single press of derecha, then steady movement
    reset_seq();
    step(B_DER, 1'b1);
    step(5'd0, 1'b1);
    paso_seen = 0;
    repeat (8) step(5'd0, 1'b1);
    chk("lit_der_paso_count", 32'(paso_seen),  32'd2);
    chk("lit_der_estado",     32'(bus.estado), 32'd4);
    chk("lit_der_accion",     32'(bus.accion), 32'd4);

    // reversal ignored, then turn up
    step(B_IZQ, 1'b1);
    step(5'd0, 1'b1);
    step(B_ARR, 1'b1);
    step(5'd0, 1'b1);
    step(5'd0, 1'b1);
    chk("lit_rev_estado", 32'(bus.estado), 32'd4);
    repeat (4) step(5'd0, 1'b1);
    chk("lit_up_estado", 32'(bus.estado), 32'd1);
    chk("lit_up_accion", 32'(bus.accion), 32'd1);

    // queue overflow
    reset_seq();
    step(B_DER, 1'b1);
    step(B_IZQ, 1'b1);
    step(B_ABA, 1'b1);
    step(B_ARR, 1'b1);
    step(B_PAU, 1'b1);
    step(B_DER, 1'b1);
    chk("lit_ovf_count", 32'(bus.q_count),    32'd4);
    chk("lit_ovf_flag",  32'(bus.q_overflow), 32'd1);
    step(5'd0, 1'b1);
    chk("lit_ovf_sticky", 32'(bus.q_overflow), 32'd1);
    repeat (20) step(5'd0, 1'b1);

    // pause from down, non-pause command discarded while paused
    reset_seq();
    step(B_ABA, 1'b1);
    step(5'd0, 1'b1);
    step(5'd0, 1'b1);
    chk("lit_aba_estado", 32'(bus.estado), 32'd2);
    step(B_PAU, 1'b1);
    repeat (3) step(5'd0, 1'b1);
    chk("lit_pau_estado",  32'(bus.estado),  32'd6);
    chk("lit_pau_accion",  32'(bus.accion),  32'd0);
    chk("lit_pau_pausado", 32'(bus.pausado), 32'd1);
    step(B_ABA, 1'b1);
    step(5'd0, 1'b1);
    step(B_PAU, 1'b1);
    step(5'd0, 1'b1);
    chk("lit_pau_hold", 32'(bus.estado), 32'd6);
    repeat (4) step(5'd0, 1'b1);
    chk("lit_resume_estado", 32'(bus.estado), 32'd2);
    chk("lit_resume_accion", 32'(bus.accion), 32'd2);

    // simultaneous arriba and pausa from start
    reset_seq();
    step(B_ARR | B_PAU, 1'b1);
    chk("lit_prio_count", 32'(bus.q_count), 32'd1);
    step(5'd0, 1'b1);
    step(5'd0, 1'b1);
    chk("lit_prio_estado", 32'(bus.estado),  32'd0);
    chk("lit_prio_drain",  32'(bus.q_count), 32'd0);

    // reset mid-queue with derecha held through release
    reset_seq();
    step(B_IZQ, 1'b1);
    step(5'd0, 1'b1);
    step(5'd0, 1'b1);
    step(B_DER, 1'b1);
    step(B_ARR, 1'b1);
    step(B_ABA, 1'b1);
    chk("lit_mid_count",  32'(bus.q_count), 32'd3);
    chk("lit_mid_estado", 32'(bus.estado),  32'd3);
    step(B_DER, 1'b0);
    chk("lit_rst_estado", 32'(bus.estado),  32'd0);
    chk("lit_rst_count",  32'(bus.q_count), 32'd0);
    repeat (8) step(B_DER, 1'b1);
    chk("lit_held_count",  32'(bus.q_count), 32'd0);
    chk("lit_held_estado", 32'(bus.estado),  32'd0);
    step(5'd0, 1'b1);

    // random traffic with occasional reset
    rb = 5'd0;
    repeat (3000) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      step(rb, ($urandom_range(0, 399) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
